// File: rtl/bin2bcd_display.sv
// Iterative binary-to-packed-BCD converter (shift-add-3), one input bit per cycle.
// Result, digit significance mask and overflow flag are held for the display between out_valid pulses.
module bin2bcd_display #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  ovf,
  output logic                  out_valid
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [BW-1:0]       scratch;
  logic [BW-1:0]       adj;
  logic                ovf_acc;
  logic [CW-1:0]       count;
  logic [DIGITS-1:0]   sig;
  logic                seen;

  assign in_ready = (state == IDLE);

  // Per-digit correction before the shift; digits never carry into each other.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A digit is significant if it or any digit above it is nonzero.
  always_comb begin
    seen = 1'b0;
    sig  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen   = seen | (scratch[4*i +: 4] != 4'd0);
      sig[i] = seen;
    end
    sig[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd       <= '0;
      digit_en  <= DIGITS'(1);
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      shreg     <= '0;
      scratch   <= '0;
      ovf_acc   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            scratch <= '0;
            ovf_acc <= 1'b0;
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], shreg[IN_WIDTH-1]};
          shreg   <= shreg << 1;
          // Any bit leaving the top digit means the value needs more than DIGITS digits.
          ovf_acc <= ovf_acc | adj[BW-1];
          count   <= count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          out_valid <= 1'b1;
          ovf       <= ovf_acc;
          state     <= IDLE;
          if (ovf_acc) begin
            bcd      <= {DIGITS{4'hE}};
            digit_en <= '1;
          end else begin
            bcd      <= scratch;
            digit_en <= sig;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
